// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling RS-232 receiver with parity,
// framing and break flags and a valid/ready holding register.
module uart_rx_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_perr,
   output logic                 m_ferr,
   output logic                 m_break,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   localparam int BITRATE = BAUD * OVERSAMPLE;
   localparam int DIV = (CLK_FREQ + BITRATE / 2) / BITRATE;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);
   localparam logic [TW-1:0] TC_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TC_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BI_END = BW'(DATA_BITS - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 ||
       OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : gBadParam
      $error("uart_rx_param: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t stateQ, stateN;
   logic [DW-1:0] divCnt;
   logic tick;
   logic sync1, rs;
   logic [TW-1:0] tc, tcN;
   logic [BW-1:0] bitIdx, bitN;
   logic [DATA_BITS-1:0] shift, shiftN;
   logic parBit, parN;
   logic ferr, ferrN;
   logic stop0, stop0N;
   logic stopCnt, stopN;
   logic waitHigh, waitN;
   logic done;
   logic ferrFin, stop0Fin, brkFin, perrFin;
   logic load, drop;

   assign tick = (divCnt == DIV_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt <= '0;
         sync1  <= 1'b1;
         rs     <= 1'b1;
      end else begin
         divCnt <= tick ? '0 : divCnt + DW'(1);
         sync1  <= rxd;
         rs     <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= IDLE;
         tc       <= '0;
         bitIdx   <= '0;
         shift    <= '0;
         parBit   <= 1'b0;
         ferr     <= 1'b0;
         stop0    <= 1'b1;
         stopCnt  <= 1'b0;
         waitHigh <= 1'b0;
      end else begin
         stateQ   <= stateN;
         tc       <= tcN;
         bitIdx   <= bitN;
         shift    <= shiftN;
         parBit   <= parN;
         ferr     <= ferrN;
         stop0    <= stop0N;
         stopCnt  <= stopN;
         waitHigh <= waitN;
      end
   end

   // Flags of the finishing word include the stop sample taken this cycle.
   assign ferrFin  = ferr | ~rs;
   assign stop0Fin = (stopCnt == 1'b0) ? rs : stop0;
   assign brkFin   = (shift == '0) && !stop0Fin && (PARITY == 0 || !parBit);

   always_comb begin
      if (PARITY == 1)      perrFin = ~(^shift ^ parBit);
      else if (PARITY == 2) perrFin = ^shift ^ parBit;
      else                  perrFin = 1'b0;
   end

   always_comb begin
      stateN = stateQ;
      tcN    = tc;
      bitN   = bitIdx;
      shiftN = shift;
      parN   = parBit;
      ferrN  = ferr;
      stop0N = stop0;
      stopN  = stopCnt;
      waitN  = waitHigh;
      done   = 1'b0;
      if (tick) begin
         tcN = tc + TW'(1);
         unique case (stateQ)
            IDLE: begin
               tcN = '0;
               // After a break the line must go high before a new start.
               if (waitHigh)  waitN = ~rs;
               else if (!rs) stateN = START;
            end
            START: if (tc == TC_MID) begin
               tcN    = '0;
               bitN   = '0;
               stateN = rs ? IDLE : DATA;
            end
            DATA: if (tc == TC_END) begin
               tcN    = '0;
               shiftN = {rs, shift[DATA_BITS-1:1]};
               bitN   = bitIdx + BW'(1);
               stopN  = 1'b0;
               ferrN  = 1'b0;
               if (bitIdx == BI_END) stateN = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (tc == TC_END) begin
               tcN    = '0;
               parN   = rs;
               stateN = STOP;
            end
            STOP: if (tc == TC_END) begin
               tcN    = '0;
               ferrN  = ferrFin;
               stop0N = stop0Fin;
               stopN  = stopCnt + 1'b1;
               if (stopCnt == STOP_LAST) begin
                  done   = 1'b1;
                  waitN  = brkFin;
                  stateN = IDLE;
               end
            end
            default: stateN = IDLE;
         endcase
      end
   end

   assign load = done && (!m_valid || m_ready);
   assign drop = done && m_valid && !m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_perr  <= 1'b0;
         m_ferr  <= 1'b0;
         m_break <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load) begin
            m_data  <= shift;
            m_perr  <= perrFin;
            m_ferr  <= ferrFin;
            m_break <= brkFin;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param in 8N1 and 7E2
// configurations at 16 clocks per bit.
module tb_uart_rx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rxd8, rdy8, clr8;
   logic rxd7, rdy7, clr7;
   logic [7:0] d8;
   logic [6:0] d7;
   logic v8, p8, f8, b8, o8;
   logic v7, p7, f7, b7, o7;

   uart_rx_param #(
      .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) u8n1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd8),
      .m_data(d8), .m_valid(v8), .m_ready(rdy8),
      .m_perr(p8), .m_ferr(f8), .m_break(b8),
      .overrun(o8), .clr_overrun(clr8)
   );

   uart_rx_param #(
      .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
      .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
   ) u7e2 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd7),
      .m_data(d7), .m_valid(v7), .m_ready(rdy7),
      .m_perr(p7), .m_ferr(f7), .m_break(b7),
      .overrun(o7), .clr_overrun(clr7)
   );

   typedef struct packed {
      logic [8:0] d;
      logic perr;
      logic ferr;
      logic brk;
   } word_t;

   typedef struct {
      bit sel;
      logic [8:0] d;
      logic par;
      logic s1;
      logic s2;
      logic [8:0] ed;
      logic ep;
      logic ef;
      logic eb;
   } vec_t;

   word_t q8[$];
   word_t q7[$];
   int nVec = 0;
   int nBad = 0;

   always @(negedge clk) begin
      if (rst_n && v8 && rdy8) q8.push_back({1'b0, d8, p8, f8, b8});
      if (rst_n && v7 && rdy7) q7.push_back({2'b0, d7, p7, f7, b7});
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic line(input bit sel, input logic v, input int n);
      if (sel) rxd7 = v;
      else     rxd8 = v;
      step(n);
   endtask

   task automatic frame(input bit sel, input logic [8:0] d,
                        input logic par, input logic s1, input logic s2);
      line(sel, 1'b0, 16);
      for (int i = 0; i < (sel ? 7 : 8); i++) line(sel, d[i], 16);
      if (sel) line(sel, par, 16);
      line(sel, s1, 16);
      if (sel) line(sel, s2, 16);
      line(sel, 1'b1, 16);
   endtask

   task automatic checkWord(input bit sel, input string nm,
                            input logic [8:0] ed, input logic ep,
                            input logic ef, input logic eb);
      word_t w;
      w = '1;
      if (sel) begin
         chk({nm, " count"}, 32'(q7.size()), 32'd1);
         if (q7.size() != 0) w = q7.pop_front();
         q7.delete();
      end else begin
         chk({nm, " count"}, 32'(q8.size()), 32'd1);
         if (q8.size() != 0) w = q8.pop_front();
         q8.delete();
      end
      chk({nm, " data"}, 32'(w.d), 32'(ed));
      chk({nm, " perr"}, 32'(w.perr), 32'(ep));
      chk({nm, " ferr"}, 32'(w.ferr), 32'(ef));
      chk({nm, " break"}, 32'(w.brk), 32'(eb));
   endtask

   vec_t vecs[11];

   initial begin
      vecs = '{
         '{1'b0, 9'hA5, 1'b0, 1'b1, 1'b1, 9'hA5, 1'b0, 1'b0, 1'b0},
         '{1'b0, 9'h00, 1'b0, 1'b1, 1'b1, 9'h00, 1'b0, 1'b0, 1'b0},
         '{1'b0, 9'hFF, 1'b0, 1'b1, 1'b1, 9'hFF, 1'b0, 1'b0, 1'b0},
         '{1'b1, 9'h35, 1'b0, 1'b1, 1'b1, 9'h35, 1'b0, 1'b0, 1'b0},
         '{1'b1, 9'h35, 1'b1, 1'b1, 1'b1, 9'h35, 1'b1, 1'b0, 1'b0},
         '{1'b1, 9'h35, 1'b0, 1'b1, 1'b0, 9'h35, 1'b0, 1'b1, 1'b0},
         '{1'b1, 9'h7F, 1'b1, 1'b1, 1'b1, 9'h7F, 1'b0, 1'b0, 1'b0},
         '{1'b1, 9'h00, 1'b0, 1'b1, 1'b0, 9'h00, 1'b0, 1'b1, 1'b0},
         '{1'b1, 9'h00, 1'b1, 1'b1, 1'b1, 9'h00, 1'b1, 1'b0, 1'b0},
         '{1'b1, 9'h01, 1'b0, 1'b0, 1'b1, 9'h01, 1'b1, 1'b1, 1'b0},
         '{1'b1, 9'h00, 1'b0, 1'b0, 1'b1, 9'h00, 1'b0, 1'b1, 1'b1}
      };

      rst_n = 1'b0;
      rxd8 = 1'b1; rdy8 = 1'b1; clr8 = 1'b0;
      rxd7 = 1'b1; rdy7 = 1'b1; clr7 = 1'b0;
      step(5);
      chk("rst v8", 32'(v8), 32'd0);
      chk("rst d8", 32'(d8), 32'd0);
      chk("rst flags8", 32'({p8, f8, b8}), 32'd0);
      chk("rst ovr8", 32'(o8), 32'd0);
      chk("rst v7", 32'(v7), 32'd0);
      chk("rst d7", 32'(d7), 32'd0);
      chk("rst ovr7", 32'(o7), 32'd0);
      rst_n = 1'b1;
      step(5);

      for (int i = 0; i < 11; i++) begin
         frame(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2);
         checkWord(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].ed,
                   vecs[i].ep, vecs[i].ef, vecs[i].eb);
      end

      // line held low for two frames: one break word, then no restart
      line(1'b0, 1'b0, 320);
      line(1'b0, 1'b1, 32);
      checkWord(1'b0, "break", 9'h00, 1'b0, 1'b1, 1'b1);
      frame(1'b0, 9'h3C, 1'b0, 1'b1, 1'b1);
      checkWord(1'b0, "after break", 9'h3C, 1'b0, 1'b0, 1'b0);

      // short glitch is a false start
      line(1'b0, 1'b0, 4);
      line(1'b0, 1'b1, 64);
      chk("glitch count", 32'(q8.size()), 32'd0);
      chk("glitch valid", 32'(v8), 32'd0);
      frame(1'b0, 9'h81, 1'b0, 1'b1, 1'b1);
      checkWord(1'b0, "after glitch", 9'h81, 1'b0, 1'b0, 1'b0);

      // overrun with consumer stalled
      rdy8 = 1'b0;
      frame(1'b0, 9'h11, 1'b0, 1'b1, 1'b1);
      frame(1'b0, 9'h22, 1'b0, 1'b1, 1'b1);
      chk("ovr data", 32'(d8), 32'h11);
      chk("ovr valid", 32'(v8), 32'd1);
      chk("ovr flag", 32'(o8), 32'd1);
      clr8 = 1'b1;
      step(1);
      clr8 = 1'b0;
      chk("ovr clr", 32'(o8), 32'd0);
      chk("ovr clr data", 32'(d8), 32'h11);
      rdy8 = 1'b1;
      step(1);
      rdy8 = 1'b0;
      chk("ovr drain valid", 32'(v8), 32'd0);
      chk("ovr drain count", 32'(q8.size()), 32'd1);
      q8.delete();

      // ready raised exactly in the completion cycle of the second word
      frame(1'b0, 9'h11, 1'b0, 1'b1, 1'b1);
      fork
         frame(1'b0, 9'h22, 1'b0, 1'b1, 1'b1);
         begin
            step(154);
            rdy8 = 1'b1;
            step(1);
            rdy8 = 1'b0;
         end
      join
      chk("swap data", 32'(d8), 32'h22);
      chk("swap valid", 32'(v8), 32'd1);
      chk("swap ovr", 32'(o8), 32'd0);
      chk("swap accepted", 32'(q8.size()), 32'd1);
      chk("swap first", 32'(q8.size() != 0 ? q8[0].d : 9'h1FF), 32'h11);
      rdy8 = 1'b1;
      step(1);
      rdy8 = 1'b0;
      q8.delete();

      // reset mid data bit 4
      frame(1'b0, 9'h33, 1'b0, 1'b1, 1'b1);
      frame(1'b0, 9'h44, 1'b0, 1'b1, 1'b1);
      chk("pre-rst ovr", 32'(o8), 32'd1);
      fork
         frame(1'b0, 9'hF0, 1'b0, 1'b1, 1'b1);
         begin
            step(88);
            rst_n = 1'b0;
            #1;
            chk("async rst valid", 32'(v8), 32'd0);
            chk("async rst data", 32'(d8), 32'd0);
            chk("async rst ovr", 32'(o8), 32'd0);
            step(3);
            rst_n = 1'b1;
         end
      join
      chk("partial lost", 32'(v8), 32'd0);
      rdy8 = 1'b1;
      q8.delete();
      frame(1'b0, 9'h5A, 1'b0, 1'b1, 1'b1);
      checkWord(1'b0, "post-reset", 9'h5A, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
